// File: rtl/exec_step_controller.sv
// exec_step_controller
// Produces the datapath clock enable for the 16-bit RISC core. Three modes:
// single-step bursts from the debounced step button, free-run paced by a
// rate divider, and a halted mode entered when the core executes a halt.
// State and an executed-cycle counter are exported for the board display.

module exec_step_controller #(
   parameter int STEP_CYCLES = 1,
   parameter int RUN_DIV     = 4,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step_pulse,
   input  logic             run_sw,
   input  logic             halt_req,
   input  logic             resume,
   output logic             cpu_en,
   output logic [1:0]       state,
   output logic             busy,
   output logic [CNT_W-1:0] cycle_count
);

   // Encoding is visible on the board display, so it is fixed explicitly.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_STEP   = 2'b01,
      ST_RUN    = 2'b10,
      ST_HALTED = 2'b11
   } state_t;

   // Both counters are 8 bits because both parameters are limited to 1..255.
   localparam logic [7:0] STEP_LOAD = 8'(STEP_CYCLES);
   localparam logic [7:0] DIV_LAST  = 8'(RUN_DIV - 1);

   state_t           state_q, state_d;
   logic             cpu_en_q, cpu_en_d;
   logic [7:0]       step_cnt_q, step_cnt_d;
   logic [7:0]       div_q, div_d;
   logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

   logic [7:0]       step_dec;
   logic             run_tick;
   logic [7:0]       div_next;

   // Next-state, enable and counter logic. The divider is held at zero
   // whenever we are not running, so the same "divider at its last value"
   // test also handles the entry edge: with RUN_DIV=1 the enable starts on
   // the entry edge, otherwise the first enable lands RUN_DIV clocks in.
   always_comb begin
      state_d       = state_q;
      cpu_en_d      = 1'b0;
      step_cnt_d    = 8'd0;
      div_d         = 8'd0;
      step_dec      = step_cnt_q - 8'd1;
      run_tick      = (div_q == DIV_LAST);
      div_next      = run_tick ? 8'd0 : (div_q + 8'd1);
      cycle_count_d = cycle_count_q + {{(CNT_W-1){1'b0}}, cpu_en_q};

      case (state_q)
         ST_IDLE: begin
            if (halt_req) begin
               state_d = ST_HALTED;
            end else if (run_sw) begin
               state_d  = ST_RUN;
               cpu_en_d = run_tick;
               div_d    = div_next;
            end else if (step_pulse) begin
               state_d    = ST_STEP;
               cpu_en_d   = 1'b1;
               step_cnt_d = STEP_LOAD;
            end
         end

         ST_STEP: begin
            if (halt_req) begin
               state_d = ST_HALTED;
            end else if (step_dec == 8'd0) begin
               state_d = ST_IDLE;
            end else begin
               cpu_en_d   = 1'b1;
               step_cnt_d = step_dec;
            end
         end

         ST_RUN: begin
            if (halt_req) begin
               state_d = ST_HALTED;
            end else if (!run_sw) begin
               state_d = ST_IDLE;
            end else begin
               cpu_en_d = run_tick;
               div_d    = div_next;
            end
         end

         ST_HALTED: begin
            if (resume && !halt_req) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered state; reset abandons any burst or run with no trailing enable.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cpu_en_q      <= 1'b0;
         step_cnt_q    <= 8'd0;
         div_q         <= 8'd0;
         cycle_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cpu_en_q      <= cpu_en_d;
         step_cnt_q    <= step_cnt_d;
         div_q         <= div_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   // Outputs come straight from flops; busy is a decode of the state flops.
   always_comb begin
      cpu_en      = cpu_en_q;
      state       = state_q;
      busy        = (state_q == ST_STEP) || (state_q == ST_RUN);
      cycle_count = cycle_count_q;
   end

endmodule

// File: tb/tb_exec_step_controller.sv
// tb_exec_step_controller
// Drives two controller instances (default parameters, and a 4-cycle step /
// continuous run / 4-bit counter variant) with directed scenarios followed
// by random traffic, comparing both against a mode-level reference model.

module tb_exec_step_controller;

   logic        clk;
   logic        reset;
   logic        step_pulse;
   logic        run_sw;
   logic        halt_req;
   logic        resume;

   logic        cpu_en_a, busy_a;
   logic [1:0]  state_a;
   logic [15:0] count_a;

   logic        cpu_en_b, busy_b;
   logic [1:0]  state_b;
   logic [3:0]  count_b;

   int total = 0;
   int bad   = 0;

   // Reference model: mode, enable for the coming clock, cycle total,
   // step cycles still owed, and clocks elapsed since entering run.
   typedef struct {
      int mode;
      int en;
      int cnt;
      int step_left;
      int run_age;
   } model_t;

   model_t mod_a, mod_b;

   exec_step_controller #(.STEP_CYCLES(1), .RUN_DIV(4), .CNT_W(16)) dut_a (
      .clk(clk), .reset(reset), .step_pulse(step_pulse), .run_sw(run_sw),
      .halt_req(halt_req), .resume(resume), .cpu_en(cpu_en_a),
      .state(state_a), .busy(busy_a), .cycle_count(count_a)
   );

   exec_step_controller #(.STEP_CYCLES(4), .RUN_DIV(1), .CNT_W(4)) dut_b (
      .clk(clk), .reset(reset), .step_pulse(step_pulse), .run_sw(run_sw),
      .halt_req(halt_req), .resume(resume), .cpu_en(cpu_en_b),
      .state(state_b), .busy(busy_b), .cycle_count(count_b)
   );

   // 10-unit clock period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock edge of behaviour, written in terms of modes and elapsed
   // clocks: run enables fall on every multiple of the divide ratio.
   function automatic model_t modelEdge(model_t m, int sc, int rd, int cw,
                                        bit r, bit st, bit rs, bit h, bit res);
      model_t n;
      n = m;
      if (r) begin
         n.mode = 0; n.en = 0; n.cnt = 0; n.step_left = 0; n.run_age = 0;
         return n;
      end
      n.cnt = (m.cnt + m.en) % (1 << cw);
      n.en  = 0;
      case (m.mode)
         0: begin
            if (h) n.mode = 3;
            else if (rs) begin
               n.mode = 2; n.run_age = 1; n.en = (1 % rd == 0) ? 1 : 0;
            end else if (st) begin
               n.mode = 1; n.en = 1; n.step_left = sc - 1;
            end
         end
         1: begin
            if (h) n.mode = 3;
            else if (m.step_left > 0) begin
               n.en = 1; n.step_left = m.step_left - 1;
            end else n.mode = 0;
         end
         2: begin
            if (h) n.mode = 3;
            else if (!rs) n.mode = 0;
            else begin
               n.run_age = m.run_age + 1;
               n.en = (n.run_age % rd == 0) ? 1 : 0;
            end
         end
         default: begin
            if (res && !h) n.mode = 0;
         end
      endcase
      return n;
   endfunction

   task automatic checkOutput(input string tag, input int observed, input int expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, observed, expected);
      end
   endtask

   // Drive one clock of inputs, advance the models, then sample just after the edge.
   task automatic applyStimulus(input bit r, input bit st, input bit rs, input bit h, input bit res);
      reset      = r;
      step_pulse = st;
      run_sw     = rs;
      halt_req   = h;
      resume     = res;
      mod_a = modelEdge(mod_a, 1, 4, 16, r, st, rs, h, res);
      mod_b = modelEdge(mod_b, 4, 1, 4,  r, st, rs, h, res);
      @(posedge clk);
      #1;
      checkOutput("a.cpu_en", int'(cpu_en_a), mod_a.en);
      checkOutput("a.state",  int'(state_a),  mod_a.mode);
      checkOutput("a.busy",   int'(busy_a),   (mod_a.mode == 1 || mod_a.mode == 2) ? 1 : 0);
      checkOutput("a.count",  int'(count_a),  mod_a.cnt);
      checkOutput("b.cpu_en", int'(cpu_en_b), mod_b.en);
      checkOutput("b.state",  int'(state_b),  mod_b.mode);
      checkOutput("b.busy",   int'(busy_b),   (mod_b.mode == 1 || mod_b.mode == 2) ? 1 : 0);
      checkOutput("b.count",  int'(count_b),  mod_b.cnt);
   endtask

   task automatic idleCycles(input int n, input bit rs, input bit h);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, rs, h, 0);
   endtask

   // Directed scenarios first, then random traffic with sticky levels.
   initial begin
      bit rs_lvl;
      bit h_lvl;
      mod_a = '{0, 0, 0, 0, 0};
      mod_b = '{0, 0, 0, 0, 0};
      reset = 1'b1; step_pulse = 1'b0; run_sw = 1'b0; halt_req = 1'b0; resume = 1'b0;
      #2;

      // Reset state, then single steps and the ignored mid-burst pulse.
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      idleCycles(8, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
      idleCycles(6, 0, 0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 1, 0, 0, 0);
         idleCycles(4, 0, 0);
      end
      applyStimulus(0, 1, 0, 0, 0);
      idleCycles(1, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
      idleCycles(6, 0, 0);

      // Free run for 20 clocks, then drop the switch.
      idleCycles(20, 1, 0);
      idleCycles(5, 0, 0);

      // Run, halt mid-run, resume while halted is refused, then real resume.
      idleCycles(6, 1, 0);
      idleCycles(3, 1, 1);
      applyStimulus(0, 0, 1, 1, 1);
      applyStimulus(0, 1, 1, 1, 0);
      applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(0, 0, 1, 0, 1);
      idleCycles(6, 1, 0);
      idleCycles(3, 0, 0);

      // Halt taken from idle and during a step burst.
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 1);
      idleCycles(2, 0, 0);

      // Step and run on the same edge, then reset in the middle of a run.
      applyStimulus(0, 1, 1, 0, 0);
      idleCycles(9, 1, 0);
      applyStimulus(1, 0, 1, 0, 0);
      idleCycles(2, 0, 0);

      // Long run to push the narrow counter through its wrap.
      idleCycles(40, 1, 0);
      idleCycles(3, 0, 0);

      // Random traffic.
      rs_lvl = 1'b0;
      h_lvl  = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) rs_lvl = ~rs_lvl;
         if ($urandom_range(0, 29) == 0) h_lvl  = ~h_lvl;
         applyStimulus($urandom_range(0, 149) == 0,
                       $urandom_range(0, 5) == 0,
                       rs_lvl, h_lvl,
                       $urandom_range(0, 7) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
